// File: rtl/verlet_step_sequencer.sv
// Frame scheduler for the rope/cloth node array: one Verlet strobe per frame, then
// NUM_ITERS solver passes over every adjacent node pair. Optional macro: PIN_ANCHOR_EN.
module verlet_step_sequencer #(
  parameter int NUM_NODES = 8,
  parameter int NUM_ITERS = 3,
  parameter int TIMEOUT   = 64,
  parameter int SEG_W     = $clog2(NUM_NODES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 solve_ack,
  output logic [NUM_NODES-1:0] verlet_en,
  output logic [NUM_NODES-1:0] fix_en,
  output logic                 solve_req,
  output logic [SEG_W-1:0]     seg_idx,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 timeout_err,
  output logic                 overrun
);

  localparam int ITER_W = (NUM_ITERS > 1) ? $clog2(NUM_ITERS) : 1;
  localparam int TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [SEG_W-1:0]     LAST_SEG  = SEG_W'(NUM_NODES - 2);
  localparam logic [ITER_W-1:0]    LAST_ITER = ITER_W'(NUM_ITERS - 1);
  localparam logic [TO_W-1:0]      TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [NUM_NODES-1:0] PAIR      = NUM_NODES'(3);

  // An anchored node 0 never integrates and never takes solver corrections.
`ifdef PIN_ANCHOR_EN
  localparam logic [NUM_NODES-1:0] NODE_MASK = ~NUM_NODES'(1);
`else
  localparam logic [NUM_NODES-1:0] NODE_MASK = '1;
`endif

  typedef enum logic [2:0] {IDLE, VERLET, REQ, COMMIT, DONE} state_t;

  state_t                state_q, state_d;
  logic [SEG_W-1:0]      seg_q, seg_d;
  logic [ITER_W-1:0]     iter_q, iter_d;
  logic [TO_W-1:0]       tmo_q, tmo_d;
  logic                  timeout_err_q, timeout_err_d;
  logic                  overrun_q, overrun_d;
  logic [NUM_NODES-1:0]  verlet_en_q, verlet_en_d;
  logic [NUM_NODES-1:0]  fix_en_q, fix_en_d;
  logic                  solve_req_q, solve_req_d;
  logic                  busy_q, busy_d;
  logic                  frame_done_q, frame_done_d;

  // Outputs are decoded from the next state and registered, so they line up with the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      seg_q         <= '0;
      iter_q        <= '0;
      tmo_q         <= '0;
      timeout_err_q <= 1'b0;
      overrun_q     <= 1'b0;
      verlet_en_q   <= '0;
      fix_en_q      <= '0;
      solve_req_q   <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      seg_q         <= seg_d;
      iter_q        <= iter_d;
      tmo_q         <= tmo_d;
      timeout_err_q <= timeout_err_d;
      overrun_q     <= overrun_d;
      verlet_en_q   <= verlet_en_d;
      fix_en_q      <= fix_en_d;
      solve_req_q   <= solve_req_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    seg_d         = seg_q;
    iter_d        = iter_q;
    tmo_d         = tmo_q;
    timeout_err_d = timeout_err_q;
    overrun_d     = overrun_q | (start & (state_q != IDLE));
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = VERLET;
          seg_d   = '0;
          iter_d  = '0;
          tmo_d   = '0;
        end
      end
      VERLET: begin
        state_d = REQ;
        tmo_d   = '0;
      end
      REQ: begin
        if (solve_req_q && solve_ack) begin
          state_d = COMMIT;
        end else if (tmo_q == TO_LAST) begin
          state_d       = IDLE;
          timeout_err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      COMMIT: begin
        tmo_d = '0;
        if (seg_q < LAST_SEG) begin
          seg_d   = seg_q + 1'b1;
          state_d = REQ;
        end else if (iter_q < LAST_ITER) begin
          seg_d   = '0;
          iter_d  = iter_q + 1'b1;
          state_d = REQ;
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    verlet_en_d  = (state_d == VERLET) ? NODE_MASK : '0;
    fix_en_d     = (state_d == COMMIT) ? ((PAIR << seg_d) & NODE_MASK) : '0;
    solve_req_d  = (state_d == REQ);
    busy_d       = (state_d != IDLE);
    frame_done_d = (state_d == DONE);
  end

  assign verlet_en   = verlet_en_q;
  assign fix_en      = fix_en_q;
  assign solve_req   = solve_req_q;
  assign seg_idx     = seg_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign timeout_err = timeout_err_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_verlet_step_sequencer.sv
// Scoreboard bench for verlet_step_sequencer: a frame-level model queues expected strobes
// with their cycle numbers, a monitor pops and compares them as the DUT presents them.
module tb_verlet_step_sequencer;

   localparam int N     = 4;
   localparam int ITERS = 2;
   localparam int TMO   = 4;
   localparam int SW    = $clog2(N);

`ifdef PIN_ANCHOR_EN
   localparam logic [N-1:0] MASK = ~N'(1);
`else
   localparam logic [N-1:0] MASK = '1;
`endif

   localparam int EV_VERLET  = 0;
   localparam int EV_COMMIT  = 1;
   localparam int EV_DONE    = 2;
   localparam int EV_TIMEOUT = 3;

   logic          clk;
   logic          reset;
   logic          start;
   logic          solve_ack;
   logic [N-1:0]  verlet_en;
   logic [N-1:0]  fix_en;
   logic          solve_req;
   logic [SW-1:0] seg_idx;
   logic          busy;
   logic          frame_done;
   logic          timeout_err;
   logic          overrun;

   typedef struct {
      int           kind;
      logic [N-1:0] vec;
      int           seg;
      int           at;
   } ev_t;

   ev_t  expQ[$];
   int   ackWaits[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   logic prevErr = 1'b0;

   verlet_step_sequencer #(
      .NUM_NODES(N),
      .NUM_ITERS(ITERS),
      .TIMEOUT(TMO)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .solve_ack(solve_ack),
      .verlet_en(verlet_en),
      .fix_en(fix_en),
      .solve_req(solve_req),
      .seg_idx(seg_idx),
      .busy(busy),
      .frame_done(frame_done),
      .timeout_err(timeout_err),
      .overrun(overrun)
   );

   // Free-running clock and a cycle counter that advances on every rising edge.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Watchdog so a stuck run still terminates with a visible failure.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      tests++;
      if (actual != expected) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Pops the next expected strobe and compares kind, vector, segment and cycle.
   task automatic matchEvent(input int kind, input logic [N-1:0] vec);
      ev_t e;
      tests++;
      if (expQ.size() == 0) begin
         fails++;
         $display("[TB] FAIL unexpected event kind=%0d vec=%b at cycle %0d, expected none", kind, vec, cyc);
      end else begin
         e = expQ.pop_front();
         if (e.kind != kind || e.vec != vec || e.at != cyc ||
             (kind == EV_COMMIT && e.seg != int'(seg_idx))) begin
            fails++;
            $display("[TB] FAIL event: got kind=%0d vec=%b seg=%0d cycle=%0d, expected kind=%0d vec=%b seg=%0d cycle=%0d",
                     kind, vec, seg_idx, cyc, e.kind, e.vec, e.seg, e.at);
         end
      end
   endtask

   // Monitor: every strobe the DUT presents is checked against the head of the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (verlet_en != '0) matchEvent(EV_VERLET, verlet_en);
            if (fix_en != '0) matchEvent(EV_COMMIT, fix_en);
            if (frame_done) matchEvent(EV_DONE, '0);
            if (timeout_err && !prevErr) matchEvent(EV_TIMEOUT, '0);
            if (solve_req) begin
               tests++;
               if (expQ.size() == 0 || !(expQ[0].kind == EV_COMMIT || expQ[0].kind == EV_TIMEOUT) ||
                   expQ[0].seg != int'(seg_idx) || verlet_en != '0 || fix_en != '0) begin
                  fails++;
                  $display("[TB] FAIL request: got seg=%0d verlet=%b fix=%b at cycle %0d, expected pending segment from model with no strobes",
                           seg_idx, verlet_en, fix_en, cyc);
               end
            end
         end
         prevErr = timeout_err;
      end
   end

   // Solver stand-in: acks each request after the wait the model chose for it.
   initial begin
      bit inReq;
      int reqCnt;
      int curWait;
      inReq = 1'b0;
      reqCnt = 0;
      curWait = 0;
      solve_ack = 1'b0;
      forever begin
         @(negedge clk);
         if (solve_req && !reset) begin
            if (!inReq) begin
               inReq = 1'b1;
               reqCnt = 0;
               curWait = (ackWaits.size() != 0) ? ackWaits.pop_front() : 0;
            end
            solve_ack = (reqCnt == curWait);
            reqCnt++;
         end else begin
            inReq = 1'b0;
            solve_ack = 1'b0;
         end
      end
   end

   // Frame model: start seen in cycle c; Verlet at c+1, then each pair costs wait+2 cycles.
   task automatic planFrame(input int c, input int minW, input int maxW, input int toReq, output int idleAt);
      ev_t e;
      int  t;
      int  r;
      int  w;
      bit  dead;
      e.kind = EV_VERLET; e.vec = MASK; e.seg = 0; e.at = c + 1;
      expQ.push_back(e);
      t = c + 2;
      r = 0;
      dead = 1'b0;
      for (int it = 0; it < ITERS && !dead; it++) begin
         for (int s = 0; s < N - 1 && !dead; s++) begin
            if (r == toReq) begin
               ackWaits.push_back(1000);
               e.kind = EV_TIMEOUT; e.vec = '0; e.seg = s; e.at = t + TMO;
               expQ.push_back(e);
               t = t + TMO;
               dead = 1'b1;
            end else begin
               w = int'($urandom_range(maxW, minW));
               ackWaits.push_back(w);
               e.kind = EV_COMMIT; e.vec = (N'(3) << s) & MASK; e.seg = s; e.at = t + w + 1;
               expQ.push_back(e);
               t = t + w + 2;
               r++;
            end
         end
      end
      if (!dead) begin
         e.kind = EV_DONE; e.vec = '0; e.seg = 0; e.at = t;
         expQ.push_back(e);
         t++;
      end
      idleAt = t;
   endtask

   task automatic applyStimulus(input int minW, input int maxW, input int toReq, input int ovrAt);
      int c;
      int idleAt;
      @(negedge clk);
      c = cyc;
      planFrame(c, minW, maxW, toReq, idleAt);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (ovrAt > 0) begin
         while (cyc < c + ovrAt) @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      while (cyc < idleAt + 1) @(negedge clk);
      checkOutput("scoreboard drained", expQ.size(), 0);
      checkOutput("busy after frame", int'(busy), 0);
   endtask

   initial begin
      int idleAt;
      int guard;
      reset = 1'b1;
      start = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("reset verlet_en", int'(verlet_en), 0);
      checkOutput("reset fix_en", int'(fix_en), 0);
      checkOutput("reset solve_req", int'(solve_req), 0);
      checkOutput("reset seg_idx", int'(seg_idx), 0);
      checkOutput("reset busy", int'(busy), 0);
      checkOutput("reset frame_done", int'(frame_done), 0);
      checkOutput("reset timeout_err", int'(timeout_err), 0);
      checkOutput("reset overrun", int'(overrun), 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      $display("[TB] zero-wait frame");
      applyStimulus(0, 0, -1, 0);
      $display("[TB] three-cycle ack delay frame");
      applyStimulus(3, 3, -1, 0);

      $display("[TB] overrun during frame");
      checkOutput("overrun before", int'(overrun), 0);
      applyStimulus(0, 0, -1, 5);
      checkOutput("overrun after", int'(overrun), 1);
      repeat (3) @(negedge clk);
      checkOutput("no second frame", int'(busy), 0);

      $display("[TB] random ack delays");
      for (int i = 0; i < 6; i++) applyStimulus(0, 3, -1, 0);

      $display("[TB] solver timeout");
      checkOutput("timeout_err before", int'(timeout_err), 0);
      applyStimulus(0, 2, int'($urandom_range(5, 0)), 0);
      checkOutput("timeout_err set", int'(timeout_err), 1);
      applyStimulus(0, 3, -1, 0);
      checkOutput("timeout_err sticky", int'(timeout_err), 1);

      $display("[TB] asynchronous reset during commit");
      @(negedge clk);
      planFrame(cyc, 0, 0, -1, idleAt);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      guard = 0;
      while (fix_en == '0 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("commit reached", int'(guard < 50), 1);
      #1 reset = 1'b1;
      #1;
      checkOutput("async reset fix_en", int'(fix_en), 0);
      checkOutput("async reset busy", int'(busy), 0);
      checkOutput("async reset solve_req", int'(solve_req), 0);
      checkOutput("async reset timeout_err", int'(timeout_err), 0);
      checkOutput("async reset overrun", int'(overrun), 0);
      expQ.delete();
      ackWaits.delete();
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("idle after reset", int'(busy), 0);
      applyStimulus(0, 3, -1, 0);
      checkOutput("overrun clear after frame", int'(overrun), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/verlet_step_sequencer.md
Name: verlet_step_sequencer

Overview:
Frame-level scheduler for the rope/cloth node array. On each frame tick it fires one Verlet integration cycle to all nodes, then runs NUM_ITERS constraint-relaxation passes over every adjacent node pair. Each pair goes through a req/ack handshake with the shared constraint solver, followed by a one-cycle commit strobe to the two affected nodes. It sits between the frame timer and the node array, and is the sole driver of the nodes' verlet_state and fix_constraint_state inputs.

Parameters:
NUM_NODES, 8, number of nodes in the chain; must be >= 2.
NUM_ITERS, 3, constraint-relaxation passes per frame; must be >= 1.
TIMEOUT, 64, maximum cycles to wait for solve_ack before aborting the frame; must be >= 1.
SEG_W, $clog2(NUM_NODES), width of seg_idx.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  frame tick; sampled only in IDLE
solve_ack  in  1  solver has corrected positions for seg_idx/seg_idx+1 ready on its outputs
verlet_en  out  NUM_NODES  per-node verlet_state strobe
fix_en  out  NUM_NODES  per-node fix_constraint_state strobe
solve_req  out  1  request solver to process segment seg_idx
seg_idx  out  SEG_W  current segment; segment k spans nodes k and k+1
busy  out  1  high in every state except IDLE
frame_done  out  1  one-cycle pulse at normal frame completion
timeout_err  out  1  sticky; set on solver timeout
overrun  out  1  sticky; set when start is high while busy

Behaviour:
- Reset (async, active-high) values:
  - state = IDLE.
  - All outputs 0; seg_idx = 0.
  - Iteration counter and timeout counter = 0.
  - timeout_err and overrun clear only on reset.
- States: IDLE, VERLET, REQ, COMMIT, DONE.
- IDLE: start=1 at a posedge moves to VERLET. Otherwise stay.
- VERLET (exactly 1 cycle):
  - verlet_en = all ones.
  - Next state REQ; seg_idx = 0; iteration = 0; timeout counter = 0.
- REQ:
  - solve_req = 1; seg_idx held stable.
  - solve_req stays high until solve_ack is sampled high at a posedge. Ack in the first REQ cycle is legal (zero wait).
  - solve_req & solve_ack at a posedge: go to COMMIT.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT-1 with no ack: set timeout_err, go to IDLE, no frame_done, drop solve_req.
- COMMIT (exactly 1 cycle):
  - fix_en has bits seg_idx and seg_idx+1 set; all other bits 0.
  - solve_req = 0.
  - Then:
    - If seg_idx < NUM_NODES-2: seg_idx+1, back to REQ.
    - Else if iteration < NUM_ITERS-1: seg_idx = 0, iteration+1, back to REQ.
    - Else: go to DONE.
  - Timeout counter clears on every entry to REQ.
- DONE (1 cycle): frame_done = 1, then IDLE. A start in this cycle is an overrun.
- Overrun: start=1 in any state other than IDLE sets overrun. The start is dropped, not queued.
- Exclusivity:
  - verlet_en and fix_en are never nonzero in the same cycle.
  - At most 2 fix_en bits are high at a time.
  - solve_req is never high together with verlet_en or fix_en.
- Latency with zero-wait ack:
  - start accepted at edge t.
  - verlet_en high in cycle t+1.
  - frame_done high in cycle t+2+2*(NUM_NODES-1)*NUM_ITERS.
  - Each ack wait cycle adds 1.
- Reset mid-frame: immediate return to IDLE with all strobes low. Nodes are left with their last committed positions.
- All outputs are registered (Moore). No combinational path from inputs to outputs.

Optional Feature:
Macro PIN_ANCHOR_EN.
- When defined:
  - Node 0 is a fixed anchor: verlet_en[0] and fix_en[0] are forced to 0 in all states.
  - Segment 0 is still solved. Its COMMIT asserts only fix_en[1].
- When undefined: every node integrates and is committed as described above.

Test Plan:
- NUM_NODES=4, NUM_ITERS=2, solve_ack tied high, start pulse at cycle 0:
  - verlet_en=4'b1111 at cycle 1.
  - seg_idx sequence 0,1,2,0,1,2.
  - fix_en sequence 0011,0110,1100 repeated twice.
  - frame_done at cycle 14.
- Same config, ack delayed 3 cycles on every request: frame_done at cycle 32; solve_req stays high and seg_idx stays stable during each wait.
- TIMEOUT=4, solve_ack held low: solve_req high 4 cycles, then timeout_err=1, busy=0, no fix_en and no frame_done. A new start runs a full frame, and timeout_err stays 1.
- start re-pulsed at cycle 5 mid-frame: overrun=1. Frame timing is unchanged (frame_done still at cycle 14) and no second frame starts.
- reset asserted asynchronously during COMMIT: fix_en and busy go to 0 before the next clk edge, state is IDLE, and both sticky flags read 0.
- With PIN_ANCHOR_EN, NUM_NODES=4: verlet_en=4'b1110, the first commit is fix_en=4'b0010, and bit 0 never rises over a full frame.
